// File: rtl/evm_vote_record_packer.sv
// Packs ballot events into 64-bit plaintext records, hands them to the Encrypter,
// and presents the returned ciphertext on a valid/ready port. Tallies and seq advance only on capture.
module evm_vote_record_packer #(
  parameter int NUM_CAND    = 8,
  parameter int ENC_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vote_valid,
  input  logic [3:0]  i_vote_cand,
  output logic        o_vote_ready,
  input  logic [63:0] i_session_key,
  output logic [0:63] o_enc_data_in,
  output logic [0:63] o_enc_key_in,
  output logic        o_enc_set,
  input  logic        i_enc_status,
  input  logic [0:63] i_enc_data_out,
  output logic        o_rec_valid,
  output logic [0:63] o_rec_data,
  input  logic        i_rec_ready,
  output logic        o_err_cand,
  output logic        o_err_timeout
);

  localparam int             TW   = (ENC_TIMEOUT > 1) ? $clog2(ENC_TIMEOUT) : 1;
  localparam logic [TW-1:0]  TLIM = TW'(ENC_TIMEOUT - 1);
  localparam logic [4:0]     NC   = 5'(NUM_CAND);

  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

  state_t        r_state;
  logic [15:0]   r_seq;
  logic [15:0]   r_tally [NUM_CAND];
  logic [15:0]   r_staged;
  logic [3:0]    r_cand;
  logic [TW-1:0] r_tcnt;

  logic          w_cand_ok;
  logic          w_accept;
  logic [15:0]   w_tally_cur;
  logic [15:0]   w_tally_next;
  logic [15:0]   w_csum;
  logic [0:63]   w_record;

  assign o_vote_ready = (r_state == IDLE) & ~i_enc_status;
  assign w_accept     = i_vote_valid & o_vote_ready;
  assign w_cand_ok    = ({1'b0, i_vote_cand} < NC);

  // Out-of-range candidates read as zero; they are rejected before anything uses the value.
  always_comb begin
    w_tally_cur = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (i_vote_cand == 4'(i)) w_tally_cur = r_tally[i];
    end
  end

  assign w_tally_next = (w_tally_cur == 16'hFFFF) ? 16'hFFFF : w_tally_cur + 16'd1;
  assign w_csum       = {8'hA5, r_seq[15:8]} + {r_seq[7:0], 4'h0, i_vote_cand} + w_tally_next;
  assign w_record     = {8'hA5, r_seq, 4'h0, i_vote_cand, w_tally_next, w_csum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_seq         <= '0;
      r_staged      <= '0;
      r_cand        <= '0;
      r_tcnt        <= '0;
      o_enc_data_in <= '0;
      o_enc_key_in  <= '0;
      o_enc_set     <= 1'b0;
      o_rec_valid   <= 1'b0;
      o_rec_data    <= '0;
      o_err_cand    <= 1'b0;
      o_err_timeout <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
    end else begin
      o_err_cand    <= 1'b0;
      o_err_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_cand_ok) begin
              o_enc_data_in <= w_record;
              o_enc_key_in  <= i_session_key;
              o_enc_set     <= 1'b1;
              r_staged      <= w_tally_next;
              r_cand        <= i_vote_cand;
              r_tcnt        <= '0;
              r_state       <= ENC;
            end else begin
              o_err_cand <= 1'b1;
            end
          end
        end
        // Status beats a coincident timeout, so a late ciphertext is still captured.
        ENC: begin
          if (i_enc_status) begin
            o_rec_data  <= i_enc_data_out;
            o_rec_valid <= 1'b1;
            o_enc_set   <= 1'b0;
            r_seq       <= r_seq + 16'd1;
            for (int i = 0; i < NUM_CAND; i++) begin
              if (r_cand == 4'(i)) r_tally[i] <= r_staged;
            end
            r_state <= OUT;
          end else if (r_tcnt == TLIM) begin
            o_enc_set     <= 1'b0;
            o_err_timeout <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        OUT: begin
          if (i_rec_ready) begin
            o_rec_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/evm_vote_record_packer.md
# evm_vote_record_packer

Upstream feeder for `Encrypter`. It accepts single ballot events from the voting panel and maintains per-candidate tallies and a session sequence number. Each vote becomes a 64-bit plaintext record that drives the `Encrypter` `data_in`/`key_in`/`set` inputs. The block waits for `status`, captures the ciphertext, and presents it on a valid/ready output to the storage/transmit stage.

## Interface
- `NUM_CAND`, 8: number of valid candidate indices (1..16).
- `ENC_TIMEOUT`, 1024: maximum cycles spent waiting for `enc_status` before the attempt is abandoned.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `vote_valid`  in  1  one-cycle vote strobe.
- `vote_cand`  in  4  candidate index.
- `vote_ready`  out  1  vote will be accepted this cycle.
- `session_key`  in  64  key for this session; sampled at vote acceptance.
- `enc_data_in`  out  [0:63]  plaintext record to `Encrypter.data_in`.
- `enc_key_in`  out  [0:63]  to `Encrypter.key_in`.
- `enc_set`  out  1  to `Encrypter.set`.
- `enc_status`  in  1  from `Encrypter.status`.
- `enc_data_out`  in  [0:63]  from `Encrypter.data_out`.
- `rec_valid`  out  1  ciphertext record available.
- `rec_data`  out  [0:63]  ciphertext record.
- `rec_ready`  in  1  downstream accepts the record.
- `err_cand`  out  1  one-cycle pulse: vote rejected because `vote_cand >= NUM_CAND`.
- `err_timeout`  out  1  one-cycle pulse: encrypt attempt abandoned.

## Operation
- Bit 0 is the MSB on all [0:63] buses.
- Record fields:
  - [0:7] = 8'hA5.
  - [8:23] = seq.
  - [24:31] = {4'h0, cand}.
  - [32:47] = tally[cand]+1, saturating at 16'hFFFF.
  - [48:63] = checksum.
- Checksum is the 16-bit sum, modulo 2^16, of words [0:15], [16:31] and [32:47].
- State: `seq` is 16 bits and wraps FFFF→0000. `tally[0..NUM_CAND-1]` are 16 bits each.
- FSM states are IDLE, ENC and OUT. Reset enters IDLE.
- `vote_ready` = (state==IDLE) & ~`enc_status`. It is combinational.
- IDLE, when `vote_valid`&`vote_ready` is sampled:
  - If cand is valid: register the record into `enc_data_in` and `session_key` into `enc_key_in`. Set `enc_set`<=1, clear the timeout counter, go to ENC.
  - If cand is invalid: pulse `err_cand`, stay in IDLE, change no state.
- `vote_valid` while `vote_ready`=0 is ignored and dropped.
- ENC, when `enc_status`=1 is sampled:
  - `rec_data`<=`enc_data_out`, `rec_valid`<=1, `enc_set`<=0.
  - Commit `seq`<=seq+1 and `tally[cand]`<=staged tally.
  - Go to OUT.
- ENC timeout: if the counter reaches `ENC_TIMEOUT`-1 without `enc_status`, set `enc_set`<=0 and pulse `err_timeout`. Go to IDLE with no commit, so `seq` and tally are unchanged.
- OUT: on `rec_valid`&`rec_ready`, `rec_valid`<=0 and go to IDLE. `rec_data` holds its value until the next capture.
- Tallies and seq commit only on a successful capture.

## Timing
- Reset values: every output register is 0 (`enc_data_in`, `enc_key_in`, `enc_set`, `rec_valid`, `rec_data`, `err_cand`, `err_timeout`). `seq`=0, all tallies=0, state=IDLE.
- `vote_ready` after reset follows ~`enc_status`.
- `rst` mid-operation returns the FSM to IDLE immediately.
  - `enc_set` and `rec_valid` drop asynchronously.
  - An in-flight record is lost and nothing is committed.
- Vote accepted at edge N: `enc_set`=1 and `enc_data_in` are valid from edge N.
- `enc_status` sampled at edge M: `rec_valid`=1 from M and `enc_set`=0 from M.
- Plaintext → ciphertext latency is M−N cycles, set entirely by `Encrypter`.
- `rec_ready` sampled at edge K: `rec_valid`=0 from K.
- The earliest next acceptance is edge K+1, and only if `enc_status` is then 0.
- `enc_data_in` and `enc_key_in` are stable throughout ENC.
- `rec_data` is stable while `rec_valid`=1.
- `enc_status` and a timeout in the same cycle: status wins, so the record is captured and `err_timeout` does not pulse.
- Error pulses last exactly 1 cycle.

## Test plan
- Reset, then vote cand 3. Stub `Encrypter` is identity, with `status` asserted 5 cycles after `set`. Required: `enc_data_in`=64'hA500_0003_0001_A504 and `rec_data` equal to it. `rec_valid` appears 5 cycles after `enc_set` rises.
- A second vote for cand 3 after the handshake gives `enc_data_in`=64'hA500_0103_0002_A605.
- Vote cand 9 with `NUM_CAND`=8. Required: `err_cand` pulses for 1 cycle, `enc_set` stays 0, and the next valid vote still uses seq 0.
- Stub never asserts `status`. Required: `err_timeout` pulses at cycle 1024 after set, `enc_set` falls, and a following vote reuses the same seq with the same tally.
- Hold `rec_ready`=0 for 20 cycles and pulse `vote_valid` meanwhile. Required: the vote is ignored, and `rec_data` is stable until `rec_ready`.
- Assert `rst` while in ENC. Required: all outputs go to 0 asynchronously, and seq and tallies read back as 0 in the next record.
